// File: rtl/bcntsync_mc.sv
// Multi-channel receive-side synchroniser for Gray-coded free-running counters.
// Brings each channel into clk, converts it to binary, reports the increment and flags multi-bit steps.
module bcntsync_mc #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NCH     = 4,
    parameter int unsigned SYNCLEN = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   gcnti,
    input  logic                   err_clr,
    output logic [NCH*WIDTH-1:0]   bcnto,
    output logic [NCH*WIDTH-1:0]   delta,
    output logic [NCH-1:0]         upd,
    output logic [NCH-1:0]         step_err,
    output logic [NCH-1:0]         err_sticky,
    output logic                   ready
);

    localparam int unsigned CNT_W = $clog2(SYNCLEN + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                                   state_q, state_d;
    logic [CNT_W-1:0]                         init_cnt_q, init_cnt_d;
    logic [NCH-1:0][SYNCLEN-1:0][WIDTH-1:0]   sync_q;
    logic [NCH-1:0][WIDTH-1:0]                gsync;
    logic [NCH-1:0][WIDTH-1:0]                gbin;
    logic [NCH-1:0][WIDTH-1:0]                gdiff;
    logic [NCH-1:0][WIDTH-1:0]                gray_prev_q, gray_prev_d;
    logic [NCH-1:0][WIDTH-1:0]                bcnto_q, bcnto_d;
    logic [NCH-1:0][WIDTH-1:0]                delta_q, delta_d;
    logic [NCH-1:0]                           upd_q, upd_d;
    logic [NCH-1:0]                           step_err_q, step_err_d;
    logic [NCH-1:0]                           sticky_q, sticky_d;
    logic                                     ready_q, ready_d;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain per bit; stage 0 is the only one that sees the async input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            for (int c = 0; c < int'(NCH); c++) begin
                sync_q[c][0] <= gcnti[c*WIDTH +: WIDTH];
                for (int s = 1; s < int'(SYNCLEN); s++) begin
                    sync_q[c][s] <= sync_q[c][s-1];
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < int'(NCH); c++) begin
            gsync[c] = sync_q[c][SYNCLEN-1];
            gbin[c]  = gray2bin(gsync[c]);
            gdiff[c] = gsync[c] ^ gray_prev_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            gray_prev_q <= '0;
            bcnto_q     <= '0;
            delta_q     <= '0;
            upd_q       <= '0;
            step_err_q  <= '0;
            sticky_q    <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            gray_prev_q <= gray_prev_d;
            bcnto_q     <= bcnto_d;
            delta_q     <= delta_d;
            upd_q       <= upd_d;
            step_err_q  <= step_err_d;
            sticky_q    <= sticky_d;
            ready_q     <= ready_d;
        end
    end

    // INIT waits for the synchronisers to fill, then seeds the reference values silently.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        gray_prev_d = gray_prev_q;
        bcnto_d     = bcnto_q;
        delta_d     = delta_q;
        upd_d       = '0;
        step_err_d  = '0;
        sticky_d    = err_clr ? '0 : sticky_q;
        ready_d     = ready_q;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == CNT_W'(SYNCLEN)) begin
                    state_d     = ST_RUN;
                    ready_d     = 1'b1;
                    gray_prev_d = gsync;
                    bcnto_d     = gbin;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                for (int c = 0; c < int'(NCH); c++) begin
                    if (gdiff[c] != '0) begin
                        bcnto_d[c]     = gbin[c];
                        delta_d[c]     = gbin[c] - bcnto_q[c];
                        upd_d[c]       = 1'b1;
                        gray_prev_d[c] = gsync[c];
                        // More than one bit set <=> clearing the lowest set bit leaves a residue.
                        step_err_d[c]  = (gdiff[c] & (gdiff[c] - WIDTH'(1))) != '0;
                        // Set has priority over a coincident clear.
                        sticky_d[c]    = sticky_d[c] | step_err_d[c];
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign bcnto      = bcnto_q;
    assign delta      = delta_q;
    assign upd        = upd_q;
    assign step_err   = step_err_q;
    assign err_sticky = sticky_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_bcntsync_mc.sv
// Directed bench for bcntsync_mc (WIDTH=8, NCH=2, SYNCLEN=2) with hand-computed expectations.
module tb_bcntsync_mc;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NCH     = 2;
    localparam int unsigned SYNCLEN = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NCH*WIDTH-1:0]  gcnti;
    logic                  err_clr;
    logic [NCH*WIDTH-1:0]  bcnto;
    logic [NCH*WIDTH-1:0]  delta;
    logic [NCH-1:0]        upd;
    logic [NCH-1:0]        step_err;
    logic [NCH-1:0]        err_sticky;
    logic                  ready;

    int n_vec;
    int n_err;

    bcntsync_mc #(
        .WIDTH   (WIDTH),
        .NCH     (NCH),
        .SYNCLEN (SYNCLEN)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gcnti      (gcnti),
        .err_clr    (err_clr),
        .bcnto      (bcnto),
        .delta      (delta),
        .upd        (upd),
        .step_err   (step_err),
        .err_sticky (err_sticky),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One active edge, then land on the falling edge for sampling and driving.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_gray(input logic [7:0] g1, input logic [7:0] g0);
        gcnti = {g1, g0};
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        err_clr = 1'b0;
        set_gray(8'h00, 8'h0F);

        // 1. reset and initialisation window
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_ready", 32'(ready), 32'd0);
            chk("rst_bcnto", 32'(bcnto), 32'd0);
            chk("rst_flags", 32'({upd, step_err, err_sticky}), 32'd0);
        end
        rst_n = 1'b1;
        tick(1);
        chk("init_ready_e1", 32'(ready), 32'd0);
        tick(1);
        chk("init_ready_e2", 32'(ready), 32'd0);
        chk("init_upd_e2", 32'(upd), 32'd0);
        tick(1);
        chk("init_ready_e3", 32'(ready), 32'd1);
        chk("init_bcnto0", 32'(bcnto[7:0]), 32'h0A);
        chk("init_bcnto1", 32'(bcnto[15:8]), 32'h00);
        chk("init_upd", 32'(upd), 32'd0);
        chk("init_delta", 32'(delta), 32'd0);

        // 2. single steps on ch0: 0x0F(10) -> 0x07(5) -> 0x05(6)
        set_gray(8'h00, 8'h07);
        tick(3);
        chk("back_bcnto0", 32'(bcnto[7:0]), 32'h05);
        chk("back_delta0", 32'(delta[7:0]), 32'hFB);
        chk("back_upd", 32'(upd), 32'b01);
        tick(1);
        set_gray(8'h00, 8'h05);
        tick(2);
        chk("step_upd_early", 32'(upd), 32'b00);
        tick(1);
        chk("step_bcnto0", 32'(bcnto[7:0]), 32'h06);
        chk("step_delta0", 32'(delta[7:0]), 32'h01);
        chk("step_upd", 32'(upd), 32'b01);
        chk("step_err", 32'(step_err), 32'b00);
        chk("step_bcnto1", 32'(bcnto[15:8]), 32'h00);
        tick(1);
        chk("step_upd_gone", 32'(upd), 32'b00);
        chk("step_hold_bcnto0", 32'(bcnto[7:0]), 32'h06);
        chk("step_hold_delta0", 32'(delta[7:0]), 32'h01);

        // 3. wrap on ch1: 0x00(0) -> 0x80(255) -> 0x00(0)
        set_gray(8'h80, 8'h05);
        tick(3);
        chk("pre_wrap_bcnto1", 32'(bcnto[15:8]), 32'hFF);
        chk("pre_wrap_delta1", 32'(delta[15:8]), 32'hFF);
        tick(1);
        set_gray(8'h00, 8'h05);
        tick(3);
        chk("wrap_bcnto1", 32'(bcnto[15:8]), 32'h00);
        chk("wrap_delta1", 32'(delta[15:8]), 32'h01);
        chk("wrap_upd", 32'(upd), 32'b10);
        chk("wrap_err", 32'(step_err), 32'b00);
        tick(1);

        // 4. fault on ch0: walk 0x05 -> 0x04 -> 0x00 legally, then 0x00 -> 0x03
        set_gray(8'h00, 8'h04);
        tick(4);
        set_gray(8'h00, 8'h00);
        tick(4);
        chk("walk_bcnto0", 32'(bcnto[7:0]), 32'h00);
        chk("walk_sticky", 32'(err_sticky), 32'b00);
        set_gray(8'h00, 8'h03);
        tick(3);
        chk("fault_step_err", 32'(step_err), 32'b01);
        chk("fault_sticky", 32'(err_sticky), 32'b01);
        chk("fault_bcnto0", 32'(bcnto[7:0]), 32'h02);
        chk("fault_delta0", 32'(delta[7:0]), 32'h02);
        tick(1);
        chk("fault_pulse_end", 32'(step_err), 32'b00);
        chk("fault_sticky_hold", 32'(err_sticky), 32'b01);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("clr_sticky", 32'(err_sticky), 32'b00);

        // 5. simultaneous legal steps, then clear coincident with a ch1 fault
        set_gray(8'h01, 8'h01);
        tick(4);
        set_gray(8'h03, 8'h03);
        tick(3);
        chk("sim_upd", 32'(upd), 32'b11);
        chk("sim_delta", 32'(delta), 32'h0101);
        chk("sim_bcnto", 32'(bcnto), 32'h0202);
        chk("sim_err", 32'(step_err), 32'b00);
        tick(1);
        set_gray(8'h00, 8'h03);
        tick(2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("coinc_step_err", 32'(step_err), 32'b10);
        chk("coinc_sticky", 32'(err_sticky), 32'b10);
        chk("coinc_delta1", 32'(delta[15:8]), 32'hFE);
        tick(1);

        // 6. reset one edge after a ch0 change: the update must be lost
        set_gray(8'h00, 8'h02);
        tick(1);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("mrst_upd", 32'(upd), 32'd0);
            chk("mrst_outs", 32'({bcnto, delta}), 32'd0);
            chk("mrst_flags", 32'({ready, step_err, err_sticky}), 32'd0);
        end
        rst_n = 1'b1;
        tick(2);
        chk("mrst_ready_e2", 32'(ready), 32'd0);
        chk("mrst_upd_e2", 32'(upd), 32'd0);
        tick(1);
        chk("mrst_ready_e3", 32'(ready), 32'd1);
        chk("mrst_bcnto", 32'(bcnto), 32'h0003);
        chk("mrst_upd_e3", 32'(upd), 32'd0);
        tick(2);
        chk("mrst_quiet", 32'(upd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcntsync_mc.md
Name: bcntsync_mc

Overview:
- Multi-channel receive-side synchroniser for free-running counters generated in foreign clock domains.
- Each channel takes a counter that is already Gray-coded and registered in its source domain. The channel synchronises it bit-wise into clk, converts it to binary and reports the per-update increment.
- Flags any sampled transition with more than one Gray bit changed, which indicates a source-side coding fault.
- Used wherever FIFO pointers, timestamps or event counters cross into the local domain.

Parameters:
- WIDTH, 16, counter width per channel in bits (>=2).
- NCH, 4, number of independent channels (>=1).
- SYNCLEN, 2, synchroniser flops per bit (>=2).

Ports:
- clk, input, 1, destination clock; all logic is in this domain.
- rst_n, input, 1, synchronous active-low reset.
- gcnti, input, NCH*WIDTH, Gray-coded counters; channel c occupies bits [c*WIDTH +: WIDTH]; asynchronous to clk.
- err_clr, input, 1, synchronous clear of all err_sticky bits.
- bcnto, output, NCH*WIDTH, synchronised binary counter values, registered.
- delta, output, NCH*WIDTH, modulo-2^WIDTH increment since the previous bcnto value, registered.
- upd, output, NCH, one-cycle pulse per channel when bcnto changed.
- step_err, output, NCH, one-cycle pulse when the sampled Gray value changed in more than 1 bit.
- err_sticky, output, NCH, latched step_err.
- ready, output, 1, high once the initialisation window has ended.

Behaviour:
- Reset:
  - Applies when rst_n is low at a clk edge.
  - Clears all synchroniser flops, the gray_prev registers, bcnto, delta, upd, step_err, err_sticky and ready to 0.
  - Returns the FSM to INIT with the init counter at 0.
  - Asserting reset mid-operation discards any update in flight; no upd is produced for it.
- Synchroniser:
  - SYNCLEN-deep flop chain per bit; the last stage is gsync[c].
  - No logic is placed between the synchroniser flops.
- FSM, shared by all channels:
  - INIT: counts SYNCLEN+1 edges after reset release. On the last INIT edge, bcnto[c] <= gray2bin(gsync[c]) and gray_prev[c] <= gsync[c]; upd, delta and step_err stay 0. Then go to RUN and set ready=1.
  - RUN: on every edge where gsync[c] != gray_prev[c]:
    - bcnto[c] <= gray2bin(gsync[c]);
    - delta[c] <= (gray2bin(gsync[c]) - bcnto[c]) mod 2^WIDTH;
    - upd[c] <= 1;
    - gray_prev[c] <= gsync[c];
    - step_err[c] <= (popcount(gsync[c] ^ gray_prev[c]) > 1).
  - In RUN, on edges with no change: upd[c]=0, step_err[c]=0, and bcnto and delta hold.
  - The FSM leaves RUN only through reset.
- Latency: a source change presented before edge k appears on bcnto/delta/upd after edge k+SYNCLEN, i.e. SYNCLEN+1 edges counting edge k.
- Wrap-around: the subtraction is modulo 2^WIDTH. Binary 2^WIDTH-1 -> 0 gives delta=1 with no error.
- Sticky error:
  - err_sticky[c] is set by step_err[c] and cleared by err_clr.
  - If err_clr and a new step_err occur on the same edge, set wins.
- Channels are fully independent; simultaneous updates on several channels are all reported on the same edge.
- Gray to binary conversion is combinational between gsync and the output registers. Binary to Gray conversion is never done here; source encoding is the sender's responsibility.

Test Plan:
1. Reset: hold rst_n=0 for 3 edges with gcnti ch0=0x0F, then release -> all outputs 0 during reset; ready=0 for 3 edges (SYNCLEN=2); then ready=1, bcnto[0]=gray2bin(0x0F)=0x000A, upd never pulses.
2. Single step (WIDTH=8, NCH=2, SYNCLEN=2): ch0 Gray 0x07 (bin 5) -> 0x05 (bin 6) -> exactly 3 edges later bcnto[0]=6, delta[0]=1, upd=2'b01 for one cycle, step_err=0; ch1 unchanged.
3. Wrap: ch1 Gray 0x80 (bin 255) -> 0x00 (bin 0) -> bcnto[1]=0, delta[1]=1, upd[1] pulse, no err.
4. Fault: ch0 Gray 0x00 -> 0x03 in one source cycle -> step_err[0] one-cycle pulse, err_sticky[0]=1, bcnto[0]=2, delta[0]=2; err_clr pulse later -> err_sticky[0]=0.
5. Simultaneous: ch0 and ch1 both step Gray 0x01 -> 0x03 on the same cycle -> upd=2'b11 on the same edge, delta=1 on both. err_clr coincident with a new fault on ch1 -> err_sticky[1] remains 1.
6. Mid-operation reset: change ch0 Gray, assert rst_n=0 one edge later -> no upd pulse; all outputs 0; after release, INIT is re-run and ready rises after 3 edges.
